touch_gesture_engine: RTL and testbench

//  Parametrised successor to the single-cycle tap/swipe recogniser. Sits after the

---
 rtl/touch_pkg.sv | 22 ++
 rtl/touch_release_debounce.sv | 38 +++
 rtl/touch_gesture_engine.sv | 170 +++++++++++++++++
 tb/tb_touch_gesture_engine.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared types for the touch gesture engine: gesture codes and FSM state encoding.
package touch_pkg;

  localparam int unsigned GC_W = 3;

  typedef enum logic [GC_W-1:0] {
    GcNone = 3'd0,
    GcTap  = 3'd1,
    GcLong = 3'd2,
    GcSwL  = 3'd3,
    GcSwR  = 3'd4,
    GcSwU  = 3'd5,
    GcSwD  = 3'd6
  } gesture_code_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPress = 2'd1,
    StHold  = 2'd2
  } touch_state_t;

endpackage

// File: rtl/touch_release_debounce.sv
// Counts consecutive invalid samples of an active touch; flags the edge that sees
// the DEBOUNCE_CYC-th consecutive low so the caller can act on that same edge.
module touch_release_debounce #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_valid,
  input  logic clear,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] LastGap = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] gap_q, gap_d;

  // Combinational so the release is decided on the edge sampling the final low.
  assign release_pulse = !clear && !sample_valid && (gap_q == LastGap);

  always_comb begin
    gap_d = gap_q;
    if (clear || sample_valid || release_pulse) begin
      gap_d = '0;
    end else if (gap_q != '1) begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/touch_gesture_engine.sv
// Classifies touches from the mapped coordinate stream into tap, long press or
// four-direction swipe, emitting one registered report pulse per gesture.
module touch_gesture_engine
  import touch_pkg::*;
#(
  parameter int unsigned COORD_W        = 10,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned DEBOUNCE_CYC   = 4,
  parameter int unsigned TAP_MAX_CYC    = 20,
  parameter int unsigned LONG_PRESS_CYC = 100,
  parameter int unsigned SWIPE_THRESH   = 40
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      touch_valid,
  input  logic        [COORD_W-1:0] touch_x,
  input  logic        [COORD_W-1:0] touch_y,
  output logic                      gesture_valid,
  output logic        [GC_W-1:0]    gesture_code,
  output logic signed [COORD_W:0]   gesture_dx,
  output logic signed [COORD_W:0]   gesture_dy,
  output logic                      busy
);

  localparam int unsigned DW = COORD_W + 1;

  localparam logic [DW-1:0]    SwipeTh = DW'(SWIPE_THRESH);
  localparam logic [CNT_W-1:0] LongCnt = CNT_W'(LONG_PRESS_CYC);
  localparam logic [CNT_W-1:0] TapMax  = CNT_W'(TAP_MAX_CYC);

  touch_state_t        state_q, state_d;
  logic [COORD_W-1:0]  start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_W-1:0]  last_x_q, last_x_d, last_y_q, last_y_d;
  logic [CNT_W-1:0]    press_cnt_q, press_cnt_d;
  logic                gv_q, gv_d;
  gesture_code_t       code_q, code_d;
  logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d;

  logic                rel_pulse;
  logic [COORD_W-1:0]  eff_x, eff_y;
  logic signed [DW-1:0] dx, dy;
  logic [DW-1:0]       adx, ady;
  logic [CNT_W-1:0]    press_cnt_inc;
  gesture_code_t       rel_code;

  touch_release_debounce #(
    .CNT_W        (CNT_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (touch_valid),
    .clear         (state_q == StIdle),
    .release_pulse (rel_pulse)
  );

  // A valid sample is included in the displacement on the edge that samples it.
  assign eff_x = touch_valid ? touch_x : last_x_q;
  assign eff_y = touch_valid ? touch_y : last_y_q;

  assign dx  = $signed({1'b0, eff_x}) - $signed({1'b0, start_x_q});
  assign dy  = $signed({1'b0, eff_y}) - $signed({1'b0, start_y_q});
  assign adx = dx[DW-1] ? -dx : dx;
  assign ady = dy[DW-1] ? -dy : dy;

  assign press_cnt_inc = (press_cnt_q == '1) ? press_cnt_q : press_cnt_q + 1'b1;

  always_comb begin
    rel_code = GcNone;
    if (adx >= SwipeTh || ady >= SwipeTh) begin
      // Equal magnitudes resolve to the horizontal axis.
      if (adx >= ady) begin
        rel_code = dx[DW-1] ? GcSwL : GcSwR;
      end else begin
        rel_code = dy[DW-1] ? GcSwU : GcSwD;
      end
    end else if (press_cnt_q <= TapMax) begin
      rel_code = GcTap;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_x_d   = start_x_q;
    start_y_d   = start_y_q;
    last_x_d    = last_x_q;
    last_y_d    = last_y_q;
    press_cnt_d = press_cnt_q;
    gv_d        = 1'b0;
    code_d      = code_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    case (state_q)
      StIdle: begin
        if (touch_valid) begin
          start_x_d   = touch_x;
          start_y_d   = touch_y;
          last_x_d    = touch_x;
          last_y_d    = touch_y;
          press_cnt_d = CNT_W'(1);
          state_d     = StPress;
        end
      end
      StPress: begin
        if (touch_valid) begin
          last_x_d    = touch_x;
          last_y_d    = touch_y;
          press_cnt_d = press_cnt_inc;
          if (press_cnt_inc == LongCnt && adx < SwipeTh && ady < SwipeTh) begin
            gv_d    = 1'b1;
            code_d  = GcLong;
            dx_d    = dx;
            dy_d    = dy;
            state_d = StHold;
          end
        end else if (rel_pulse) begin
          state_d = StIdle;
          if (rel_code != GcNone) begin
            gv_d   = 1'b1;
            code_d = rel_code;
            dx_d   = dx;
            dy_d   = dy;
          end
        end
      end
      StHold: begin
        if (touch_valid) begin
          last_x_d = touch_x;
          last_y_d = touch_y;
        end else if (rel_pulse) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_x_q   <= '0;
      start_y_q   <= '0;
      last_x_q    <= '0;
      last_y_q    <= '0;
      press_cnt_q <= '0;
      gv_q        <= 1'b0;
      code_q      <= GcNone;
      dx_q        <= '0;
      dy_q        <= '0;
    end else begin
      state_q     <= state_d;
      start_x_q   <= start_x_d;
      start_y_q   <= start_y_d;
      last_x_q    <= last_x_d;
      last_y_q    <= last_y_d;
      press_cnt_q <= press_cnt_d;
      gv_q        <= gv_d;
      code_q      <= code_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
    end
  end

  assign gesture_valid = gv_q;
  assign gesture_code  = code_q;
  assign gesture_dx    = dx_q;
  assign gesture_dy    = dy_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_touch_gesture_engine.sv
// Directed bench for touch_gesture_engine with hand-computed expectations.
module tb_touch_gesture_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic               touch_valid;
  logic        [9:0]  touch_x;
  logic        [9:0]  touch_y;
  logic               gesture_valid;
  logic        [2:0]  gesture_code;
  logic signed [10:0] gesture_dx;
  logic signed [10:0] gesture_dy;
  logic               busy;

  int n_cmp  = 0;
  int n_err  = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  touch_gesture_engine dut (
    .clk           (clk),
    .reset         (reset),
    .touch_valid   (touch_valid),
    .touch_x       (touch_x),
    .touch_y       (touch_y),
    .gesture_valid (gesture_valid),
    .gesture_code  (gesture_code),
    .gesture_dx    (gesture_dx),
    .gesture_dy    (gesture_dy),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input int x, input int y);
    touch_valid = v;
    touch_x     = 10'(x);
    touch_y     = 10'(y);
    @(posedge clk);
    #1;
    if (gesture_valid) pulses++;
  endtask

  task automatic lows(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  initial begin
    reset       = 1'b1;
    touch_valid = 1'b0;
    touch_x     = '0;
    touch_y     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", gesture_valid, 0);
    check("rst code", gesture_code, 0);
    check("rst dx", gesture_dx, 0);
    check("rst dy", gesture_dy, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;

    // Tap: pulse exactly on the 4th low edge
    pulses = 0;
    repeat (10) step(1'b1, 100, 100);
    check("tap busy", busy, 1);
    lows(3);
    check("tap early", pulses, 0);
    lows(1);
    check("tap valid", gesture_valid, 1);
    check("tap code", gesture_code, 1);
    check("tap dx", gesture_dx, 0);
    check("tap dy", gesture_dy, 0);
    check("tap idle", busy, 0);
    lows(1);
    check("tap one cycle", gesture_valid, 0);
    check("tap code hold", gesture_code, 1);

    // Glitch: a 3-low gap must not end the press
    pulses = 0;
    repeat (10) step(1'b1, 100, 100);
    lows(3);
    repeat (5) step(1'b1, 100, 100);
    lows(3);
    check("glitch no pulse", pulses, 0);
    lows(1);
    check("glitch valid", gesture_valid, 1);
    check("glitch code", gesture_code, 1);
    check("glitch pulses", pulses, 1);

    // Swipe right: x 100..300
    pulses = 0;
    for (int i = 0; i <= 20; i++) step(1'b1, 100 + 10 * i, 200);
    lows(4);
    check("swr valid", gesture_valid, 1);
    check("swr code", gesture_code, 4);
    check("swr dx", gesture_dx, 200);
    check("swr dy", gesture_dy, 0);

    // Swipe up: y 500..400
    for (int i = 0; i <= 10; i++) step(1'b1, 300, 500 - 10 * i);
    lows(4);
    check("swu code", gesture_code, 5);
    check("swu dx", gesture_dx, 0);
    check("swu dy", gesture_dy, -100);
    check("swu pulses", pulses, 2);

    // Diagonal tie at threshold resolves horizontally
    step(1'b1, 100, 100);
    step(1'b1, 140, 60);
    lows(4);
    check("diag valid", gesture_valid, 1);
    check("diag code", gesture_code, 4);
    check("diag dx", gesture_dx, 40);
    check("diag dy", gesture_dy, -40);

    // Long press: report on the 100th valid sample, silent release
    pulses = 0;
    repeat (99) step(1'b1, 50, 50);
    check("long early", pulses, 0);
    step(1'b1, 50, 50);
    check("long valid", gesture_valid, 1);
    check("long code", gesture_code, 2);
    check("long dx", gesture_dx, 0);
    check("long hold busy", busy, 1);
    repeat (10) step(1'b1, 52, 49);
    lows(4);
    check("long release", pulses, 1);
    check("long idle", busy, 0);
    check("long code hold", gesture_code, 2);

    // Medium press: too long for tap, too short for long
    pulses = 0;
    repeat (50) step(1'b1, 60, 60);
    check("med busy", busy, 1);
    lows(4);
    check("med no pulse", pulses, 0);
    check("med idle", busy, 0);

    // Reset mid-swipe aborts, then a short press taps
    pulses = 0;
    for (int i = 0; i < 30; i++) step(1'b1, 100 + 10 * i, 300);
    reset = 1'b1;
    #1;
    check("abort valid", gesture_valid, 0);
    check("abort code", gesture_code, 0);
    check("abort dx", gesture_dx, 0);
    check("abort busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    lows(2);
    check("abort no pulse", pulses, 0);
    repeat (5) step(1'b1, 200, 200);
    lows(4);
    check("post tap valid", gesture_valid, 1);
    check("post tap code", gesture_code, 1);
    check("post tap dx", gesture_dx, 0);
    check("post tap dy", gesture_dy, 0);
    check("post tap pulses", pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
